// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy/fill engine: memory geometry, FSM states, mode codes.
package mem_copy_engine_pkg;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned AW        = 16;
  localparam int unsigned DW        = 16;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  function automatic logic [AW-1:0] step_ptr(input logic [AW-1:0] ptr, input logic desc);
    if (desc) begin
      step_ptr = ptr - AW'(1'b1);
    end else begin
      step_ptr = ptr + AW'(1'b1);
    end
  endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// Word-memory bus between the copy engine (master) and the data memory (slave).
interface mem_copy_engine_if;
  import mem_copy_engine_pkg::*;

  logic [AW-1:0] M_Adr;
  logic          M_Wr;
  logic          M_Rd;
  logic [DW-1:0] M_D_i;
  logic [DW-1:0] M_D_o;

  modport master (output M_Adr, output M_Wr, output M_Rd, output M_D_i, input M_D_o);
  modport slave  (input M_Adr, input M_Wr, input M_Rd, input M_D_i, output M_D_o);
endinterface

// File: rtl/mem_copy_engine_range_chk.sv
// Checks that the block [base, base+len) fits inside the memory; sum taken one bit wider.
module mem_copy_engine_range_chk
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_DEPTH
) (
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          ok
);

  logic [AW:0] end_s;

  assign end_s = {1'b0, base} + {1'b0, len};
  assign ok    = (end_s <= (AW+1)'(DEPTH));

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy / fill initiator for the data memory; the CPU stalls while Busy is high.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_DEPTH
) (
  input  logic              Clock_Puls,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Mode,
  input  logic [AW-1:0]     Src_Adr,
  input  logic [AW-1:0]     Dst_Adr,
  input  logic [AW-1:0]     Len,
  input  logic [DW-1:0]     Fill_Val,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [AW-1:0]     Words_Done,
  mem_copy_engine_if.master mem
);

  state_e        state_q, state_d;
  logic          mode_q, mode_d, desc_q, desc_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d, words_done_q, words_done_d;
  logic [DW-1:0] data_q, data_d, fill_q, fill_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          m_wr_q, m_wr_d, m_rd_q, m_rd_d;
  logic [AW-1:0] m_adr_q, m_adr_d;
  logic [DW-1:0] m_d_i_q, m_d_i_d;

  logic          src_ok_s, dst_ok_s, desc_s;
  logic [AW:0]   src_end_s;
  logic [AW-1:0] len_m1_s;

  mem_copy_engine_range_chk #(.DEPTH(DEPTH)) u_src_chk (.base(Src_Adr), .len(Len), .ok(src_ok_s));
  mem_copy_engine_range_chk #(.DEPTH(DEPTH)) u_dst_chk (.base(Dst_Adr), .len(Len), .ok(dst_ok_s));

  // Overlapping copy with the destination above the source must run top-down.
  assign src_end_s = {1'b0, Src_Adr} + {1'b0, Len};
  assign desc_s    = (Mode == MODE_COPY) && (Src_Adr < Dst_Adr) && ({1'b0, Dst_Adr} < src_end_s);
  assign len_m1_s  = Len - AW'(1'b1);

  // Next-state, pointer and registered-output computation.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    desc_d       = desc_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    words_done_d = words_done_q;
    data_d       = data_q;
    fill_d       = fill_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          words_done_d = '0;
          mode_d       = Mode;
          fill_d       = Fill_Val;
          desc_d       = desc_s;
          rem_d        = Len;
          if (Len == '0) begin
            done_d = 1'b1;
          end else if (!dst_ok_s || ((Mode == MODE_COPY) && !src_ok_s)) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            src_d   = desc_s ? (Src_Adr + len_m1_s) : Src_Adr;
            dst_d   = desc_s ? (Dst_Adr + len_m1_s) : Dst_Adr;
            state_d = (Mode == MODE_COPY) ? ST_READ : ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        data_d = mem.M_D_o;
        src_d  = step_ptr(src_q, desc_q);
        if (Abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        words_done_d = words_done_q + AW'(1'b1);
        dst_d        = step_ptr(dst_q, desc_q);
        rem_d        = rem_q - AW'(1'b1);
        if (Abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (rem_q == AW'(1'b1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (mode_q == MODE_COPY) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    m_rd_d = (state_d == ST_READ);
    m_wr_d = (state_d == ST_WRITE);
    if (state_d == ST_READ) begin
      m_adr_d = src_d;
    end else if (state_d == ST_WRITE) begin
      m_adr_d = dst_d;
    end else begin
      m_adr_d = '0;
    end
    if (state_d == ST_WRITE) begin
      m_d_i_d = (mode_d == MODE_FILL) ? fill_d : data_d;
    end else begin
      m_d_i_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock_Puls) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_COPY;
      desc_q       <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      words_done_q <= '0;
      data_q       <= '0;
      fill_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      m_wr_q       <= 1'b0;
      m_rd_q       <= 1'b0;
      m_adr_q      <= '0;
      m_d_i_q      <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      desc_q       <= desc_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      words_done_q <= words_done_d;
      data_q       <= data_d;
      fill_q       <= fill_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      m_wr_q       <= m_wr_d;
      m_rd_q       <= m_rd_d;
      m_adr_q      <= m_adr_d;
      m_d_i_q      <= m_d_i_d;
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign Words_Done = words_done_q;
  assign mem.M_Adr  = m_adr_q;
  assign mem.M_Wr   = m_wr_q;
  assign mem.M_Rd   = m_rd_q;
  assign mem.M_D_i  = m_d_i_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench: engine plus 1024-word data memory; expected writes are queued at command issue and
// matched against observed bus writes.
module tb_mem_copy_engine;
  import mem_copy_engine_pkg::*;

  logic        Clock_Puls = 1'b0;
  logic        Reset;
  logic        Start, Abort, Mode;
  logic [15:0] Src_Adr, Dst_Adr, Len, Fill_Val;
  logic        Busy, Done, Err;
  logic [15:0] Words_Done;

  logic [15:0] mem  [0:1023];
  logic [15:0] snap [0:1023];
  logic        tb_wr;
  logic [9:0]  tb_adr;
  logic [15:0] tb_dat;

  logic [31:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc_cnt = 0;

  mem_copy_engine_if mem_if ();

  mem_copy_engine dut (
    .Clock_Puls(Clock_Puls), .Reset(Reset), .Start(Start), .Abort(Abort), .Mode(Mode),
    .Src_Adr(Src_Adr), .Dst_Adr(Dst_Adr), .Len(Len), .Fill_Val(Fill_Val),
    .Busy(Busy), .Done(Done), .Err(Err), .Words_Done(Words_Done), .mem(mem_if)
  );

  always #5 Clock_Puls = ~Clock_Puls;

  assign mem_if.M_D_o = mem[mem_if.M_Adr[9:0]];

  always @(posedge Clock_Puls) begin
    if (tb_wr) begin
      mem[tb_adr] <= tb_dat;
    end else if (mem_if.M_Wr) begin
      mem[mem_if.M_Adr[9:0]] <= mem_if.M_D_i;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: every write must match the head of the expected-write queue.
  always @(negedge Clock_Puls) begin
    if (mem_if.M_Wr || mem_if.M_Rd) acc_cnt++;
    if (mem_if.M_Wr) begin
      check_val("rd_wr_excl", {31'd0, mem_if.M_Rd}, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_wr_adr", {16'd0, mem_if.M_Adr}, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_val("wr_adr", {16'd0, mem_if.M_Adr}, {16'd0, e[31:16]});
        check_val("wr_data", {16'd0, mem_if.M_D_i}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic mem_load(input int adr, input logic [15:0] dat);
    tb_adr = adr[9:0];
    tb_dat = dat;
    tb_wr  = 1'b1;
    @(posedge Clock_Puls);
    #1 tb_wr = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic mode, input int src, input int dst,
                         input int len, input logic [15:0] fill, input int exp_busy,
                         input logic exp_err, input int exp_wd, input logic abort_with_start);
    int n, acc0;
    logic desc;
    snap = mem;
    desc = (mode == MODE_COPY) && (src < dst) && (dst < src + len);
    if (!exp_err) begin
      for (int i = 0; i < len; i++) begin
        int k;
        k = desc ? (len - 1 - i) : i;
        exp_q.push_back({16'(dst + k), (mode == MODE_FILL) ? fill : snap[src + k]});
      end
    end
    acc0     = acc_cnt;
    Mode     = mode;
    Src_Adr  = 16'(src);
    Dst_Adr  = 16'(dst);
    Len      = 16'(len);
    Fill_Val = fill;
    Start    = 1'b1;
    Abort    = abort_with_start;
    @(posedge Clock_Puls);
    #1 Start = 1'b0;
    Abort = 1'b0;
    n = 0;
    @(negedge Clock_Puls);
    while (Busy && n < 5000) begin
      n++;
      @(negedge Clock_Puls);
    end
    check_val({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    check_val({tag, "_done"}, {31'd0, Done}, 32'd1);
    check_val({tag, "_err"}, {31'd0, Err}, {31'd0, exp_err});
    check_val({tag, "_words_done"}, {16'd0, Words_Done}, 32'(exp_wd));
    check_val({tag, "_accesses"}, 32'(acc_cnt - acc0), 32'(exp_busy));
    @(negedge Clock_Puls);
    check_val({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
    check_val({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    if (!exp_err) begin
      for (int i = 0; i < len; i++) begin
        check_val({tag, "_mem"}, {16'd0, mem[dst + i]},
                  {16'd0, (mode == MODE_FILL) ? fill : snap[src + i]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected $finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Mode = 1'b0; tb_wr = 1'b0;
    Src_Adr = '0; Dst_Adr = '0; Len = '0; Fill_Val = '0; tb_adr = '0; tb_dat = '0;
    for (int i = 0; i < 4; i++) mem_load(i, 16'(i + 1));
    for (int i = 0; i < 5; i++) mem_load(10 + i, 16'hA0A0 + 16'(i));
    for (int i = 0; i < 8; i++) mem_load(200 + i, 16'h2000 + 16'(i));
    mem_load(1019, 16'h1111);
    for (int i = 0; i < 4; i++) mem_load(500 + i, 16'h5555);
    @(negedge Clock_Puls);
    check_val("rst_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_done", {31'd0, Done}, 32'd0);
    check_val("rst_err", {31'd0, Err}, 32'd0);
    check_val("rst_bus", {mem_if.M_Wr, mem_if.M_Rd, mem_if.M_Adr[13:0], mem_if.M_D_i}, 32'd0);
    check_val("rst_words_done", {16'd0, Words_Done}, 32'd0);
    #1 Reset = 1'b0;
    @(posedge Clock_Puls); #1;

    run_cmd("copy_asc", MODE_COPY, 0, 100, 4, 16'h0, 8, 1'b0, 4, 1'b0);
    run_cmd("copy_desc", MODE_COPY, 10, 12, 5, 16'h0, 10, 1'b0, 5, 1'b0);
    run_cmd("fill_top", MODE_FILL, 0, 1020, 4, 16'hBEEF, 4, 1'b0, 4, 1'b1);
    check_val("fill_top_below", {16'd0, mem[1019]}, 32'h1111);
    run_cmd("fill_range", MODE_FILL, 0, 1022, 4, 16'hDEAD, 0, 1'b1, 0, 1'b0);
    run_cmd("len_zero", MODE_COPY, 0, 300, 0, 16'h0, 0, 1'b0, 0, 1'b0);
    run_cmd("src_range", MODE_COPY, 1020, 0, 8, 16'h0, 0, 1'b1, 0, 1'b0);

    // Abort during the second READ: only the first word lands.
    snap = mem;
    exp_q.push_back({16'd300, snap[200]});
    Mode = MODE_COPY; Src_Adr = 16'd200; Dst_Adr = 16'd300; Len = 16'd8; Start = 1'b1;
    @(posedge Clock_Puls); #1 Start = 1'b0;
    @(posedge Clock_Puls);
    @(posedge Clock_Puls); #1 Abort = 1'b1;
    @(posedge Clock_Puls); #1 Abort = 1'b0;
    @(negedge Clock_Puls);
    check_val("abort_done", {31'd0, Done}, 32'd1);
    check_val("abort_err", {31'd0, Err}, 32'd1);
    check_val("abort_busy", {31'd0, Busy}, 32'd0);
    check_val("abort_words_done", {16'd0, Words_Done}, 32'd1);
    repeat (3) @(negedge Clock_Puls);
    check_val("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    check_val("abort_mem_next", {16'd0, mem[301]}, {16'd0, snap[301]});

    // Reset during the second WRITE: that write lands, nothing after it.
    exp_q.push_back({16'd500, mem[0]});
    exp_q.push_back({16'd501, mem[1]});
    Src_Adr = 16'd0; Dst_Adr = 16'd500; Len = 16'd4; Start = 1'b1;
    @(posedge Clock_Puls); #1 Start = 1'b0;
    repeat (3) @(posedge Clock_Puls);
    #1 Reset = 1'b1;
    @(negedge Clock_Puls);
    @(negedge Clock_Puls);
    check_val("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_mid_flags", {30'd0, Done, Err}, 32'd0);
    check_val("rst_mid_bus", {mem_if.M_Wr, mem_if.M_Rd, mem_if.M_Adr[13:0], mem_if.M_D_i}, 32'd0);
    check_val("rst_mid_words_done", {16'd0, Words_Done}, 32'd0);
    #1 Reset = 1'b0;
    repeat (4) @(negedge Clock_Puls);
    check_val("rst_mid_queue", 32'(exp_q.size()), 32'd0);
    check_val("rst_mid_w0", {16'd0, mem[500]}, 32'd1);
    check_val("rst_mid_w1", {16'd0, mem[501]}, 32'd2);
    check_val("rst_mid_w2", {16'd0, mem[502]}, 32'h5555);
    check_val("rst_mid_w3", {16'd0, mem[503]}, 32'h5555);
    #1;
    run_cmd("post_rst_fill", MODE_FILL, 0, 600, 2, 16'h1234, 2, 1'b0, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
